// File: rtl/tx_packet_arbiter_if.sv
// Bus bundle for tx_packet_arbiter: pixel byte stream in, housekeeping word
// request in, tx FIFO write side out, plus the busy status.
//   slave  : the arbiter (consumes px/hk requests, drives the FIFO write port)
//   master : whoever sources pixels / housekeeping and sinks FIFO writes
interface tx_packet_arbiter_if;
  logic        px_valid;
  logic [7:0]  px_data;
  logic        px_last;
  logic        px_ready;
  logic        hk_req;
  logic [31:0] hk_data;
  logic        hk_ack;
  logic        tx_fifo_wfull;
  logic        tx_fifo_winc;
  logic [7:0]  tx_fifo_wdata;
  logic        busy;

  modport master (
    output px_valid, px_data, px_last, hk_req, hk_data, tx_fifo_wfull,
    input  px_ready, hk_ack, tx_fifo_winc, tx_fifo_wdata, busy
  );

  modport slave (
    input  px_valid, px_data, px_last, hk_req, hk_data, tx_fifo_wfull,
    output px_ready, hk_ack, tx_fifo_winc, tx_fifo_wdata, busy
  );
endinterface

// File: rtl/tx_packet_arbiter.sv
// tx_packet_arbiter
// Shares the tx FIFO write port between the CCD pixel byte stream and
// housekeeping words. Every transfer is framed as a packet:
//   pixel : HDR_PX, len, seq, payload[0..len-1]
//   hk    : HDR_HK, seq, word[7:0], [15:8], [23:16], [31:24]
// Pixels are staged in a PX_BURST-byte buffer so capture keeps running while
// a housekeeping packet is emitted.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   bus      : tx_packet_arbiter_if.slave (px_valid/px_data/px_last/px_ready,
//              hk_req/hk_data/hk_ack, tx_fifo_wfull/tx_fifo_winc/
//              tx_fifo_wdata, busy)
module tx_packet_arbiter #(
  parameter int unsigned PX_BURST = 16,
  parameter logic [7:0]  HDR_PX   = 8'hA5,
  parameter logic [7:0]  HDR_HK   = 8'h5A
) (
  input  logic               clk,
  input  logic               rst,
  tx_packet_arbiter_if.slave bus
);
  localparam int unsigned IDX_W     = (PX_BURST > 1) ? $clog2(PX_BURST) : 1;
  localparam logic [7:0]  BURST_LEN = 8'(PX_BURST);

  typedef enum logic [2:0] {
    IDLE, HK_HDR, HK_SEQ, HK_DATA, PX_HDR, PX_LEN, PX_SEQ, PX_DATA
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  idx_q, idx_d;          // payload byte index in HK_DATA / PX_DATA
  logic [7:0]  seq_q, seq_d;
  logic        last_hk_q, last_hk_d;  // 1: most recent grant went to hk
  logic        hk_ack_q, hk_ack_d;
  logic [7:0]  count_q, count_d;
  logic        complete_q, complete_d;
  logic        winc_q, winc_d;
  logic [7:0]  wdata_q, wdata_d;
  logic [31:0] hk_word_q, hk_word_d;
  logic [7:0]  px_buf_q [PX_BURST];
  logic [7:0]  px_buf_d [PX_BURST];

  logic       in_px;
  logic       px_ready;
  logic       px_fire;
  logic       slot;
  logic       grant_hk;
  logic       grant_px;
  logic [7:0] emit_byte;

  assign in_px    = (state_q == PX_HDR) || (state_q == PX_LEN) ||
                    (state_q == PX_SEQ) || (state_q == PX_DATA);
  assign px_ready = !rst && !complete_q && !in_px;
  assign px_fire  = bus.px_valid && px_ready;
  // One write at most every other cycle: never decide a write while the
  // previous strobe is still on the bus.
  assign slot     = !bus.tx_fifo_wfull && !winc_q;
  // Round robin on a tie: the side that did not win last time goes first.
  assign grant_hk = bus.hk_req && (!complete_q || !last_hk_q);
  assign grant_px = complete_q && !grant_hk;

  // State register (control state is reset, staged data is not)
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      idx_q      <= 8'd0;
      seq_q      <= 8'd0;
      last_hk_q  <= 1'b0;
      hk_ack_q   <= 1'b0;
      count_q    <= 8'd0;
      complete_q <= 1'b0;
      winc_q     <= 1'b0;
      wdata_q    <= 8'd0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      seq_q      <= seq_d;
      last_hk_q  <= last_hk_d;
      hk_ack_q   <= hk_ack_d;
      count_q    <= count_d;
      complete_q <= complete_d;
      winc_q     <= winc_d;
      wdata_q    <= wdata_d;
    end
  end

  always_ff @(posedge clk) begin
    hk_word_q <= hk_word_d;
    px_buf_q  <= px_buf_d;
  end

  // Next-state logic: pixel capture, arbitration, packet sequencing
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    seq_d      = seq_q;
    last_hk_d  = last_hk_q;
    hk_word_d  = hk_word_q;
    count_d    = count_q;
    complete_d = complete_q;
    px_buf_d   = px_buf_q;

    // Capture never overlaps PX_* states (px_ready is low there), so it
    // cannot collide with the buffer release at the end of a pixel packet.
    if (px_fire) begin
      px_buf_d[count_q[IDX_W-1:0]] = bus.px_data;
      count_d = count_q + 8'd1;
      if ((count_d == BURST_LEN) || bus.px_last) complete_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        idx_d = 8'd0;
        if (grant_hk) begin
          state_d   = HK_HDR;
          last_hk_d = 1'b1;
          hk_word_d = bus.hk_data;
        end else if (grant_px) begin
          state_d   = PX_HDR;
          last_hk_d = 1'b0;
        end
      end
      HK_HDR:  if (slot) begin state_d = HK_SEQ; seq_d = seq_q + 8'd1; end
      HK_SEQ:  if (slot) state_d = HK_DATA;
      HK_DATA: if (slot) begin
        idx_d = idx_q + 8'd1;
        if (idx_q == 8'd3) state_d = IDLE;
      end
      PX_HDR:  if (slot) begin state_d = PX_LEN; seq_d = seq_q + 8'd1; end
      PX_LEN:  if (slot) state_d = PX_SEQ;
      PX_SEQ:  if (slot) state_d = PX_DATA;
      PX_DATA: if (slot) begin
        idx_d = idx_q + 8'd1;
        if (idx_q == count_q - 8'd1) begin
          state_d    = IDLE;
          count_d    = 8'd0;
          complete_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic: byte selection and registered write strobe / hk_ack
  always_comb begin
    emit_byte = 8'h00;
    case (state_q)
      HK_HDR:  emit_byte = HDR_HK;
      // seq already advanced on the header write; the packet carries the
      // value from before that increment.
      HK_SEQ:  emit_byte = seq_q - 8'd1;
      HK_DATA: emit_byte = hk_word_q[{idx_q[1:0], 3'b000} +: 8];
      PX_HDR:  emit_byte = HDR_PX;
      PX_LEN:  emit_byte = count_q;
      PX_SEQ:  emit_byte = seq_q - 8'd1;
      PX_DATA: emit_byte = px_buf_q[idx_q[IDX_W-1:0]];
      default: emit_byte = 8'h00;
    endcase

    winc_d   = slot && (state_q != IDLE);
    wdata_d  = winc_d ? emit_byte : wdata_q;
    hk_ack_d = (state_q == IDLE) && grant_hk;
  end

  assign bus.px_ready      = px_ready;
  assign bus.hk_ack        = hk_ack_q;
  assign bus.tx_fifo_winc  = winc_q;
  assign bus.tx_fifo_wdata = wdata_q;
  assign bus.busy          = (state_q != IDLE);
endmodule

// File: tb/tb_tx_packet_arbiter.sv
// Testbench for tx_packet_arbiter: directed scenarios plus a randomized run,
// all checked against a packet-level reference model of the FIFO byte stream.
module tb_tx_packet_arbiter;
  localparam int PXB = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  tx_packet_arbiter_if bus();

  tx_packet_arbiter #(.PX_BURST(PXB), .HDR_PX(8'hA5), .HDR_HK(8'h5A)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks   = 0;
  int failures = 0;

  // FIFO-side observation
  logic [7:0] got[$];
  int   b2b_cnt = 0;
  int   wf_viol = 0;
  int   ack_cnt = 0;
  logic prev_winc  = 1'b0;
  logic prev_wfull = 1'b0;

  // Backpressure sources
  logic bp_force = 1'b0;
  logic bp_rand  = 1'b0;
  logic rnd_full = 1'b0;
  bit   gaps     = 1'b0;
  assign bus.tx_fifo_wfull = bp_force | (bp_rand & rnd_full);

  always @(posedge clk) begin
    #1;
    rnd_full = ($urandom_range(0, 2) == 0);
  end

  always @(negedge clk) begin
    if (bus.tx_fifo_winc === 1'b1) begin
      got.push_back(bus.tx_fifo_wdata);
      if (prev_winc)  b2b_cnt++;
      if (prev_wfull) wf_viol++;
    end
    if (bus.hk_ack === 1'b1) ack_cnt++;
    prev_winc  = bus.tx_fifo_winc;
    prev_wfull = bus.tx_fifo_wfull;
  end

  // Reference model: expected FIFO byte stream built from packet rules
  logic [7:0] exp_q[$];
  int m_seq;
  bit m_last_hk;

  function automatic void m_reset();
    m_seq = 0;
    m_last_hk = 1'b0;
    exp_q.delete();
  endfunction

  function automatic void m_hk(input logic [31:0] d);
    exp_q.push_back(8'h5A);
    exp_q.push_back(8'(m_seq));
    for (int k = 0; k < 4; k++) exp_q.push_back(d[8*k +: 8]);
    m_seq = (m_seq + 1) % 256;
    m_last_hk = 1'b1;
  endfunction

  function automatic void m_px(input logic [7:0] line[$]);
    int pos;
    int n;
    pos = 0;
    while (pos < line.size()) begin
      n = line.size() - pos;
      if (n > PXB) n = PXB;
      exp_q.push_back(8'hA5);
      exp_q.push_back(8'(n));
      exp_q.push_back(8'(m_seq));
      m_seq = (m_seq + 1) % 256;
      for (int k = 0; k < n; k++) exp_q.push_back(line[pos + k]);
      pos += n;
    end
    m_last_hk = 1'b0;
  endfunction

  // Both requesters present together: the one that did not win last goes first.
  function automatic void m_tie(input logic [31:0] d, input logic [7:0] line[$]);
    if (!m_last_hk) begin
      m_hk(d);
      m_px(line);
    end else begin
      m_px(line);
      m_hk(d);
    end
  endfunction

  // First position where observed stream (from base) and model stream differ.
  task automatic stream_diff(input int base, output int idx,
                             output logic [7:0] g, output logic [7:0] e);
    int n;
    int lim;
    n = got.size() - base;
    lim = (n > exp_q.size()) ? n : exp_q.size();
    idx = -1;
    g = 8'hxx;
    e = 8'hxx;
    for (int i = 0; i < lim; i++) begin
      if (i >= n || i >= exp_q.size() || got[base + i] !== exp_q[i]) begin
        idx = i;
        if (i < n) g = got[base + i];
        if (i < exp_q.size()) e = exp_q[i];
        break;
      end
    end
  endtask

  // Stimulus helpers
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.px_valid = 1'b0;
    bus.px_last  = 1'b0;
    bus.hk_req   = 1'b0;
    bp_force = 1'b0;
    bp_rand  = 1'b0;
    gaps     = 1'b0;
    tick(2);
    rst = 1'b0;
    m_reset();
  endtask

  task automatic send_px(input logic [7:0] line[$]);
    bit done;
    for (int i = 0; i < line.size(); i++) begin
      done = 1'b0;
      if (gaps && $urandom_range(0, 3) == 0) begin
        bus.px_valid = 1'b0;
        tick($urandom_range(1, 3));
      end
      bus.px_valid = 1'b1;
      bus.px_data  = line[i];
      bus.px_last  = (i == line.size() - 1);
      for (int c = 0; c < 500 && !done; c++) begin
        @(negedge clk);
        done = bus.px_ready;
        @(posedge clk);
        #1;
      end
      if (!done) begin
        checks++;
        failures++;
        $display("FAIL px_accept: byte %0d never accepted, px_ready stayed 0 (required 1)", i);
        break;
      end
    end
    bus.px_valid = 1'b0;
    bus.px_last  = 1'b0;
  endtask

  task automatic do_hk(input logic [31:0] d);
    bit acked;
    acked = 1'b0;
    bus.hk_data = d;
    bus.hk_req  = 1'b1;
    for (int c = 0; c < 500 && !acked; c++) begin
      @(negedge clk);
      acked = bus.hk_ack;
      @(posedge clk);
      #1;
    end
    bus.hk_req = 1'b0;
    if (!acked) begin
      checks++;
      failures++;
      $display("FAIL hk_ack_wait: hk_ack never seen for %08h (required a pulse)", d);
    end
  endtask

  task automatic wait_idle(input string name);
    int stable;
    stable = 0;
    for (int c = 0; c < 3000 && stable < 3; c++) begin
      @(negedge clk);
      #1;
      if (!bus.busy && bus.px_ready && !bus.tx_fifo_winc) stable++;
      else stable = 0;
    end
    @(posedge clk);
    #1;
    if (stable < 3) begin
      checks++;
      failures++;
      $display("FAIL %s idle_wait: busy=%0b px_ready=%0b (required 0/1)", name, bus.busy, bus.px_ready);
    end
  endtask

  // Scenarios
  task automatic test_reset();
    rst = 1'b1;
    tick(2);
    @(negedge clk); #1;
    checks++; if (bus.tx_fifo_winc !== 1'b0) begin failures++; $display("FAIL reset_winc: got %0b required 0", bus.tx_fifo_winc); end
    checks++; if (bus.tx_fifo_wdata !== 8'h00) begin failures++; $display("FAIL reset_wdata: got %02h required 00", bus.tx_fifo_wdata); end
    checks++; if (bus.hk_ack !== 1'b0) begin failures++; $display("FAIL reset_hk_ack: got %0b required 0", bus.hk_ack); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %0b required 0", bus.busy); end
    checks++; if (bus.px_ready !== 1'b0) begin failures++; $display("FAIL reset_px_ready_in_rst: got %0b required 0", bus.px_ready); end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk); #1;
    checks++; if (bus.px_ready !== 1'b1) begin failures++; $display("FAIL reset_px_ready_after: got %0b required 1", bus.px_ready); end
    @(posedge clk); #1;
    m_reset();
  endtask

  task automatic test_hk_only();
    int base, a0, b0, di;
    logic [7:0] dg, de;
    do_reset();
    base = got.size(); a0 = ack_cnt; b0 = b2b_cnt;
    m_hk(32'hDEADBEEF);
    bus.hk_data = 32'hDEADBEEF;
    bus.hk_req  = 1'b1;
    @(negedge clk); #1;
    checks++; if (bus.hk_ack !== 1'b0) begin failures++; $display("FAIL hk_ack_early: got %0b required 0", bus.hk_ack); end
    @(negedge clk); #1;
    checks++; if (bus.hk_ack !== 1'b1) begin failures++; $display("FAIL hk_ack_latency: got %0b required 1", bus.hk_ack); end
    checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL hk_busy: got %0b required 1", bus.busy); end
    @(posedge clk); #1;
    bus.hk_req = 1'b0;
    @(negedge clk); #1;
    checks++; if (bus.tx_fifo_winc !== 1'b1 || bus.tx_fifo_wdata !== 8'h5A) begin
      failures++; $display("FAIL hk_hdr_latency: winc=%0b wdata=%02h required 1/5a", bus.tx_fifo_winc, bus.tx_fifo_wdata);
    end
    wait_idle("hk_only");
    stream_diff(base, di, dg, de);
    checks++; if (di !== -1) begin failures++; $display("FAIL hk_stream: byte %0d got %02h required %02h (%0d bytes vs %0d)", di, dg, de, got.size() - base, exp_q.size()); end
    checks++; if (ack_cnt - a0 !== 1) begin failures++; $display("FAIL hk_ack_count: got %0d required 1", ack_cnt - a0); end
    checks++; if (b2b_cnt !== b0) begin failures++; $display("FAIL hk_b2b_winc: got %0d required 0", b2b_cnt - b0); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL hk_busy_end: got %0b required 0", bus.busy); end
  endtask

  task automatic test_short_line();
    int base, di, bad;
    logic [7:0] dg, de;
    logic [7:0] line[$];
    do_reset();
    base = got.size(); bad = 0;
    line.push_back(8'h11); line.push_back(8'h22); line.push_back(8'h33);
    m_px(line);
    send_px(line);
    for (int c = 0; c < 200 && (got.size() - base) < 6; c++) begin
      @(negedge clk); #1;
      if ((got.size() - base) < 6 && bus.px_ready !== 1'b0) bad++;
    end
    checks++; if (bad !== 0) begin failures++; $display("FAIL short_px_ready_low: high in %0d cycles, required 0", bad); end
    checks++; if (bus.px_ready !== 1'b1) begin failures++; $display("FAIL short_px_ready_reassert: got %0b required 1", bus.px_ready); end
    wait_idle("short_line");
    stream_diff(base, di, dg, de);
    checks++; if (di !== -1) begin failures++; $display("FAIL short_stream: byte %0d got %02h required %02h (%0d bytes vs %0d)", di, dg, de, got.size() - base, exp_q.size()); end
  endtask

  task automatic test_long_line();
    int base, di, b0;
    logic [7:0] dg, de;
    logic [7:0] line[$];
    do_reset();
    base = got.size(); b0 = b2b_cnt;
    for (int i = 0; i < 40; i++) line.push_back(8'(i));
    m_px(line);
    send_px(line);
    wait_idle("long_line");
    stream_diff(base, di, dg, de);
    checks++; if (di !== -1) begin failures++; $display("FAIL long_stream: byte %0d got %02h required %02h (%0d bytes vs %0d)", di, dg, de, got.size() - base, exp_q.size()); end
    checks++; if (b2b_cnt !== b0) begin failures++; $display("FAIL long_b2b_winc: got %0d required 0", b2b_cnt - b0); end
  endtask

  task automatic test_tie();
    int base, di;
    logic [7:0] dg, de;
    logic [7:0] l1[$];
    logic [7:0] l2[$];
    do_reset();
    base = got.size();
    l1.push_back(8'hC1); l1.push_back(8'hC2); l1.push_back(8'hC3);
    m_tie(32'h11223344, l1);
    send_px(l1);
    do_hk(32'h11223344);
    wait_idle("tie1");
    checks++; if ((got.size() - base) < 1 || got[base] !== 8'h5A) begin
      failures++; $display("FAIL tie1_first: first header got %02h required 5a", (got.size() > base) ? got[base] : 8'hxx);
    end
    m_hk(32'h55667788);
    do_hk(32'h55667788);
    wait_idle("tie_lone_hk");
    l2.push_back(8'hD1); l2.push_back(8'hD2); l2.push_back(8'hD3);
    m_tie(32'h99AABBCC, l2);
    send_px(l2);
    do_hk(32'h99AABBCC);
    wait_idle("tie2");
    checks++; if ((got.size() - base) < 19 || got[base + 18] !== 8'hA5) begin
      failures++; $display("FAIL tie2_first: first header got %02h required a5", (got.size() > base + 18) ? got[base + 18] : 8'hxx);
    end
    stream_diff(base, di, dg, de);
    checks++; if (di !== -1) begin failures++; $display("FAIL tie_stream: byte %0d got %02h required %02h (%0d bytes vs %0d)", di, dg, de, got.size() - base, exp_q.size()); end
  endtask

  task automatic test_backpressure();
    int base, di, w, f0, sz;
    logic [7:0] dg, de;
    logic [7:0] line[$];
    do_reset();
    base = got.size(); w = 0; f0 = wf_viol;
    for (int i = 0; i < 8; i++) line.push_back(8'h60 + 8'(i));
    m_px(line);
    send_px(line);
    for (int c = 0; c < 200 && (got.size() - base) < 5; c++) begin
      @(negedge clk); #1;
    end
    @(posedge clk); #1;
    bp_force = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk); #1;
      if (bus.tx_fifo_winc !== 1'b0) w++;
    end
    sz = got.size() - base;
    @(posedge clk); #1;
    bp_force = 1'b0;
    checks++; if (w !== 0) begin failures++; $display("FAIL bp_winc_while_full: got %0d strobes required 0", w); end
    checks++; if (sz !== 5) begin failures++; $display("FAIL bp_bytes_at_stall: got %0d required 5", sz); end
    for (int c = 0; c < 200 && (got.size() - base) < 6; c++) begin
      @(negedge clk); #1;
    end
    checks++; if ((got.size() - base) < 6 || got[base + 5] !== 8'h62) begin
      failures++; $display("FAIL bp_resume_byte: got %02h required 62", (got.size() > base + 5) ? got[base + 5] : 8'hxx);
    end
    wait_idle("backpressure");
    stream_diff(base, di, dg, de);
    checks++; if (di !== -1) begin failures++; $display("FAIL bp_stream: byte %0d got %02h required %02h (%0d bytes vs %0d)", di, dg, de, got.size() - base, exp_q.size()); end
    checks++; if (wf_viol !== f0) begin failures++; $display("FAIL bp_write_after_full: got %0d required 0", wf_viol - f0); end
  endtask

  task automatic test_reset_mid();
    int base, base2, di;
    logic [7:0] dg, de;
    logic [7:0] line[$];
    do_reset();
    base = got.size();
    for (int i = 0; i < 10; i++) line.push_back(8'h70 + 8'(i));
    send_px(line);
    for (int c = 0; c < 200 && (got.size() - base) < 5; c++) begin
      @(negedge clk); #1;
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk); #1;
    checks++; if (bus.px_ready !== 1'b0) begin failures++; $display("FAIL rmid_px_ready: got %0b required 0", bus.px_ready); end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk); #1;
    checks++; if (bus.tx_fifo_winc !== 1'b0) begin failures++; $display("FAIL rmid_winc: got %0b required 0", bus.tx_fifo_winc); end
    checks++; if (bus.hk_ack !== 1'b0) begin failures++; $display("FAIL rmid_hk_ack: got %0b required 0", bus.hk_ack); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL rmid_busy: got %0b required 0", bus.busy); end
    base2 = got.size();
    tick(8);
    checks++; if (got.size() !== base2) begin failures++; $display("FAIL rmid_no_writes: got %0d bytes required 0", got.size() - base2); end
    m_reset();
    m_hk(32'hCAFEF00D);
    do_hk(32'hCAFEF00D);
    wait_idle("reset_mid");
    checks++; if ((got.size() - base2) < 2 || got[base2 + 1] !== 8'h00) begin
      failures++; $display("FAIL rmid_seq: got %02h required 00", (got.size() > base2 + 1) ? got[base2 + 1] : 8'hxx);
    end
    stream_diff(base2, di, dg, de);
    checks++; if (di !== -1) begin failures++; $display("FAIL rmid_stream: byte %0d got %02h required %02h (%0d bytes vs %0d)", di, dg, de, got.size() - base2, exp_q.size()); end
  endtask

  task automatic test_random();
    int base, di, a0, b0, f0, nhk, n;
    logic [7:0] dg, de;
    logic [31:0] d;
    logic [7:0] line[$];
    do_reset();
    base = got.size(); a0 = ack_cnt; b0 = b2b_cnt; f0 = wf_viol; nhk = 0;
    gaps = 1'b1;
    bp_rand = 1'b1;
    for (int it = 0; it < 25; it++) begin
      if ($urandom_range(0, 2) == 0) begin
        d = $urandom;
        m_hk(d);
        do_hk(d);
        nhk++;
      end else begin
        n = $urandom_range(1, 40);
        line.delete();
        for (int i = 0; i < n; i++) line.push_back(8'($urandom_range(0, 255)));
        m_px(line);
        send_px(line);
      end
      wait_idle("random");
    end
    gaps = 1'b0;
    bp_rand = 1'b0;
    stream_diff(base, di, dg, de);
    checks++; if (di !== -1) begin failures++; $display("FAIL rand_stream: byte %0d got %02h required %02h (%0d bytes vs %0d)", di, dg, de, got.size() - base, exp_q.size()); end
    checks++; if (ack_cnt - a0 !== nhk) begin failures++; $display("FAIL rand_ack_count: got %0d required %0d", ack_cnt - a0, nhk); end
    checks++; if (b2b_cnt !== b0) begin failures++; $display("FAIL rand_b2b_winc: got %0d required 0", b2b_cnt - b0); end
    checks++; if (wf_viol !== f0) begin failures++; $display("FAIL rand_write_after_full: got %0d required 0", wf_viol - f0); end
  endtask

  initial begin
    rst = 1'b1;
    bus.px_valid = 1'b0;
    bus.px_data  = 8'h00;
    bus.px_last  = 1'b0;
    bus.hk_req   = 1'b0;
    bus.hk_data  = 32'h0;
    m_reset();
    test_reset();
    test_hk_only();
    test_short_line();
    test_long_line();
    test_tie();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1, "watchdog");
  end
endmodule
